// File: rtl/dial_encoder_pkg.sv
// dial_pkg: shared types and helpers for the dial encoder emulator.
//   POS_W / CODE_W : encoder position width (8) and vault code width (5)
//   pos_t / code_t : position and code types
//   state_t        : controller states (BOUNCE only reachable with DIAL_BOUNCE_EN)
//   bin2gray       : binary to reflected Gray conversion
package dial_pkg;

  localparam int POS_W  = 8;
  localparam int CODE_W = 5;

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [CODE_W-1:0] code_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SPIN   = 3'd1,
    SEEK   = 3'd2,
    DONE   = 3'd3,
    BOUNCE = 3'd4
  } state_t;

  function automatic pos_t bin2gray(input pos_t b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/dial_encoder_if.sv
// dial_encoder_if: "dial to code" command handshake.
//   cmd_valid : request (master -> slave)
//   cmd_ready : slave can accept (slave -> master)
//   cmd_code  : target vault code
//   cmd_dir   : 1 = CW (increment), 0 = CCW (decrement)
//   cmd_turns : full revolutions to spin before seeking
interface dial_encoder_if;
  import dial_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  code_t      cmd_code;
  logic       cmd_dir;
  logic [1:0] cmd_turns;

  modport master (
    output cmd_valid, cmd_code, cmd_dir, cmd_turns,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_code, cmd_dir, cmd_turns,
    output cmd_ready
  );

endinterface

// File: rtl/dial_encoder_step_timer.sv
// step_timer: paces encoder steps.
//   clock, reset : clock and synchronous active-high reset
//   en           : count while high (hold otherwise)
//   clear        : restart the count at 0 (wins over en)
//   tick         : high on the cycle the count equals STEP_DIV-1
// STEP_DIV legal range 1..255.
module step_timer #(
  parameter int STEP_DIV = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(STEP_DIV - 1);

  logic [7:0] cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= 8'd0;
    end else if (clear) begin
      cnt <= 8'd0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? 8'd0 : cnt + 8'd1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/dial_encoder.sv
// dial_encoder: rotary encoder emulator. Turns a "dial to code" command into
// a paced sequence of Gray-coded absolute positions suitable for the vault's
// re_in.
//   clock, reset : clock and synchronous active-high reset
//   cmd          : command handshake (dial_encoder_if.slave)
//   re_out       : Gray-coded position, pos ^ (pos >> 1)
//   position     : binary position (debug)
//   busy         : command in progress (SPIN/SEEK/BOUNCE/DONE)
//   done         : one-cycle completion pulse
// Build option: define DIAL_BOUNCE_EN to add a one-step overshoot and return
// after arrival (extra BOUNCE state, adds 2*STEP_DIV cycles).
//
// state  | meaning
// IDLE   | ready for a command
// SPIN   | full revolutions, steps_left counts down to 0
// SEEK   | stepping until pos[7:3] == code
// BOUNCE | overshoot one step past landing, then step back
// DONE   | one-cycle done pulse
module dial_encoder
  import dial_pkg::*;
#(
  parameter int STEP_DIV = 4
) (
  input  logic           clock,
  input  logic           reset,
  dial_encoder_if.slave  cmd,
  output pos_t           re_out,
  output pos_t           position,
  output logic           busy,
  output logic           done
);

  state_t     state, next_state;
  pos_t       pos, pos_next;
  code_t      code_q;
  logic       dir_q;
  logic [9:0] steps_left;
  logic       tick;
  logic       accept;
  logic       arrived;
  logic       step;
  logic       step_up;
  logic       timer_en;
  logic       timer_clear;
  logic       busy_d;
  logic       done_d;
`ifdef DIAL_BOUNCE_EN
  logic       phase;
`endif

  assign cmd.cmd_ready = (state == IDLE) && !reset;
  assign accept        = cmd.cmd_valid && cmd.cmd_ready;
  assign arrived       = (pos[7:3] == code_q);
  assign position      = pos;

  step_timer #(.STEP_DIV(STEP_DIV)) u_timer (
    .clock (clock),
    .reset (reset),
    .en    (timer_en),
    .clear (timer_clear),
    .tick  (tick)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) begin
          next_state = (cmd.cmd_turns != 2'd0) ? SPIN : SEEK;
        end
      end
      SPIN: begin
        // the last revolution step hands over to SEEK on the same edge
        if (tick && (steps_left == 10'd1)) begin
          next_state = SEEK;
        end
      end
      SEEK: begin
        if (arrived) begin
`ifdef DIAL_BOUNCE_EN
          next_state = BOUNCE;
`else
          next_state = DONE;
`endif
        end
      end
`ifdef DIAL_BOUNCE_EN
      BOUNCE: begin
        if (tick && phase) begin
          next_state = DONE;
        end
      end
`endif
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_comb begin
    step        = 1'b0;
    step_up     = dir_q;
    timer_en    = 1'b0;
    timer_clear = accept;
    busy_d      = (next_state != IDLE);
    done_d      = (next_state == DONE);
    case (state)
      SPIN: begin
        timer_en = 1'b1;
        step     = tick;
      end
      SEEK: begin
        timer_en = 1'b1;
        // arrival is checked before stepping, so a tick on the arrival cycle
        // never moves past the landing position
        step     = tick && !arrived;
`ifdef DIAL_BOUNCE_EN
        // restart pacing so each bounce step takes a full STEP_DIV
        timer_clear = arrived;
`endif
      end
`ifdef DIAL_BOUNCE_EN
      BOUNCE: begin
        timer_en = 1'b1;
        step     = tick;
        step_up  = dir_q ^ phase;
      end
`endif
      default: begin
      end
    endcase
    pos_next = step_up ? pos + 8'd1 : pos - 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pos        <= '0;
      re_out     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      code_q     <= '0;
      dir_q      <= 1'b0;
      steps_left <= 10'd0;
`ifdef DIAL_BOUNCE_EN
      phase      <= 1'b0;
`endif
    end else begin
      busy <= busy_d;
      done <= done_d;
      if (accept) begin
        code_q     <= cmd.cmd_code;
        dir_q      <= cmd.cmd_dir;
        steps_left <= {cmd.cmd_turns, 8'h00};
`ifdef DIAL_BOUNCE_EN
        phase      <= 1'b0;
`endif
      end
      if (step) begin
        pos    <= pos_next;
        re_out <= bin2gray(pos_next);
      end
      if ((state == SPIN) && tick) begin
        steps_left <= steps_left - 10'd1;
      end
`ifdef DIAL_BOUNCE_EN
      if ((state == BOUNCE) && tick) begin
        phase <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_dial_encoder.sv
module tb_dial_encoder;
  import dial_pkg::*;

  localparam int SD = 4;

  logic clock = 1'b0;
  logic reset;
  pos_t re_out;
  pos_t position;
  logic busy;
  logic done;

  dial_encoder_if cmd_if ();

  dial_encoder #(.STEP_DIV(SD)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd      (cmd_if.slave),
    .re_out   (re_out),
    .position (position),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] pos;
    int         lat;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model_pos;
  int         wrap_seen;

  function automatic logic [7:0] gray(input logic [7:0] b);
    return b ^ {1'b0, b[7:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // reference model: walk the dial one step at a time until the code window
  task automatic push_cmd(input logic [4:0] c, input logic d, input logic [1:0] t);
    exp_t       e;
    int         n;
    logic [7:0] q;
    n = 0;
    q = model_pos;
    while ((q[7:3] != c) && (n < 300)) begin
      q = d ? q + 8'd1 : q - 8'd1;
      n++;
    end
    e.pos = q;
    e.lat = (int'(t) * 256 + n) * SD + 2;
`ifdef DIAL_BOUNCE_EN
    e.lat = e.lat + 2 * SD;
`endif
    model_pos = q;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [4:0] c, input logic d, input logic [1:0] t);
    @(negedge clock);
    check("ready_before_cmd", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_code  = c;
    cmd_if.cmd_dir   = d;
    cmd_if.cmd_turns = t;
  endtask

  task automatic wait_done(input int raise_at, input logic [4:0] rc, input logic rd,
                           input logic [1:0] rt, output logic [7:0] max_pos);
    int   n;
    bit   got;
    exp_t e;
    n       = 0;
    got     = 0;
    max_pos = 8'd0;
    while (!got && (n < 3000)) begin
      @(negedge clock);
      n++;
      if (n == 1) cmd_if.cmd_valid = 1'b0;
      if ((raise_at > 0) && (n == raise_at)) begin
        check("busy_reject_ready", cmd_if.cmd_ready, 0);
        check("busy_reject_busy", busy, 1);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_code  = rc;
        cmd_if.cmd_dir   = rd;
        cmd_if.cmd_turns = rt;
      end
      if (position > max_pos) max_pos = position;
      if (done === 1'b1) got = 1;
    end
    check("done_seen", got, 1);
    if (got) begin
      check("sb_nonempty", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("done_latency", n, e.lat);
        check("land_position", position, e.pos);
        check("land_re_out", re_out, gray(e.pos));
        check("busy_with_done", busy, 1);
      end
      @(negedge clock);
      check("done_one_cycle", done, 0);
      check("ready_after_done", cmd_if.cmd_ready, 1);
      check("idle_not_busy", busy, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_position", position, 0);
    check("rst_re_out", re_out, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", cmd_if.cmd_ready, 0);
    reset = 1'b0;
    model_pos = 8'd0;
  endtask

  // every observed move is a single +/-1 step with a single-bit Gray change
  logic [7:0] prev_pos;
  logic [7:0] prev_re;
  logic       prev_rst = 1'b1;

  always @(negedge clock) begin
    if ((reset === 1'b0) && !prev_rst) begin
      check("gray_map", re_out, gray(position));
      if (position !== prev_pos) begin
        check("step_size", ((position - prev_pos) == 8'd1) || ((prev_pos - position) == 8'd1), 1);
        check("gray_one_bit", $countones(re_out ^ prev_re), 1);
        if ((prev_pos == 8'hFF) && (position == 8'h00)) wrap_seen++;
      end
    end
    prev_pos = position;
    prev_re  = re_out;
    prev_rst = (reset !== 1'b0);
  end

  initial begin
    logic [7:0] peak;
    int         n;
    int         dn;
    logic [7:0] exp_peak;

    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_code  = '0;
    cmd_if.cmd_dir   = 1'b0;
    cmd_if.cmd_turns = 2'd0;
    reset     = 1'b1;
    model_pos = 8'd0;
    wrap_seen = 0;

    repeat (3) @(negedge clock);
    check("reset_position", position, 0);
    check("reset_re_out", re_out, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_ready", cmd_if.cmd_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_after_reset", cmd_if.cmd_ready, 1);

    // basic CW seek: code 2 from 0 -> pos 16, re_out 0x18
    drive(5'd2, 1'b1, 2'd0);
    push_cmd(5'd2, 1'b1, 2'd0);
    wait_done(0, 5'd0, 1'b0, 2'd0, peak);
`ifdef DIAL_BOUNCE_EN
    exp_peak = 8'd17;
`else
    exp_peak = 8'd16;
`endif
    check("t1_peak_position", peak, exp_peak);
    check("t1_re_out_0x18", re_out, 8'h18);

    // already there: zero steps
    drive(5'd2, 1'b1, 2'd0);
    push_cmd(5'd2, 1'b1, 2'd0);
    wait_done(0, 5'd0, 1'b0, 2'd0, peak);

    // CCW single step: 16 -> 15, re_out 0x08
    drive(5'd1, 1'b0, 2'd0);
    push_cmd(5'd1, 1'b0, 2'd0);
    wait_done(0, 5'd0, 1'b0, 2'd0, peak);
    check("t2_re_out_0x08", re_out, 8'h08);

    // CCW wrap: 0 -> 255, re_out 0x80
    do_reset();
    drive(5'd31, 1'b0, 2'd0);
    push_cmd(5'd31, 1'b0, 2'd0);
    wait_done(0, 5'd0, 1'b0, 2'd0, peak);
    check("t3_re_out_0x80", re_out, 8'h80);

    // full revolution with a second command held while busy
    do_reset();
    wrap_seen = 0;
    drive(5'd0, 1'b1, 2'd1);
    push_cmd(5'd0, 1'b1, 2'd1);
    wait_done(10, 5'd5, 1'b1, 2'd0, peak);
    check("t4_wrap_seen_once", wrap_seen, 1);
    push_cmd(5'd5, 1'b1, 2'd0);
    wait_done(0, 5'd0, 1'b0, 2'd0, peak);

    // already inside the window, CCW: zero steps
    drive(5'd5, 1'b0, 2'd0);
    push_cmd(5'd5, 1'b0, 2'd0);
    wait_done(0, 5'd0, 1'b0, 2'd0, peak);

    // reset mid-spin at pos 100
    drive(5'd0, 1'b1, 2'd2);
    n = 0;
    while ((position !== 8'd100) && (n < 3000)) begin
      @(negedge clock);
      n++;
      if (n == 1) cmd_if.cmd_valid = 1'b0;
    end
    check("spin_reached_100", position, 8'd100);
    check("spin_busy", busy, 1);
    reset = 1'b1;
    @(negedge clock);
    check("abort_position", position, 0);
    check("abort_re_out", re_out, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    reset = 1'b0;
    model_pos = 8'd0;
    dn = 0;
    repeat (6) begin
      @(negedge clock);
      if (done !== 1'b0) dn++;
    end
    check("abort_no_done", dn, 0);
    check("abort_ready", cmd_if.cmd_ready, 1);
    check("abort_position_held", position, 0);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dial_encoder.md
Name: dial_encoder

Overview:
- Emulates the vault's rotary encoder: turns a "dial to code" command into a stepped sequence of 8-bit Gray-coded absolute positions on re_out.
- re_out is shaped to drive the vault's re_in directly, for self-test, demo and bench stimulus.
- Sits on the same slow clock domain as the vault controller.
- Produces the dial motion (CW/CCW, optional full revolutions) that the direction decoder and vault controller consume.

Parameters:
- STEP_DIV, 4: clock cycles per encoder step; legal range 1..255.
- POS_W, 8: encoder position width; fixed at 8, not to be overridden.
- CODE_W, 5: vault code width; vault code = position[7:3].

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  block can accept a command
- cmd_code  in  5  target vault code
- cmd_dir  in  1  1 = CW (position increments), 0 = CCW (position decrements)
- cmd_turns  in  2  full revolutions (256 steps each) to spin before seeking
- re_out  out  8  Gray-coded position: pos ^ (pos >> 1)
- position  out  8  binary position (debug)
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse

Behaviour:
- Clock and reset: one clock, clock. Reset is synchronous and active-high.
- Reset values: pos=0, re_out=0, position=0, busy=0, done=0, cmd_ready=0 while reset high. State goes to IDLE; cmd_ready is 1 on the first cycle after reset drops.
- All outputs are registered. re_out and position change only on step cycles.
- FSM states: IDLE, SPIN, SEEK, DONE.
- IDLE:
  - cmd_ready=1, busy=0.
  - On cmd_valid&&cmd_ready: latch code, dir and steps_left = cmd_turns*256 (10-bit); clear tick counter.
  - Next state is SPIN if cmd_turns!=0, else SEEK.
  - cmd_valid while cmd_ready=0 is ignored; no queuing.
- Step tick:
  - Tick counter counts 0..STEP_DIV-1 in SPIN and SEEK.
  - A step happens on the cycle the counter equals STEP_DIV-1.
  - First step lands STEP_DIV cycles after the accept cycle.
- Step arithmetic:
  - CW: pos+1, modulo 256 (255 -> 0).
  - CCW: pos-1, modulo 256 (0 -> 255).
- SPIN:
  - Each step decrements steps_left.
  - When steps_left reaches 0, go to SEEK; pos is back at the start value.
- SEEK:
  - Arrival test: pos[7:3]==code.
  - Tested on the entry cycle and after each step.
  - If already true on entry, zero steps are taken.
  - Landing position is the first position matching in the commanded direction: CW lands on {code,3'b000}, CCW lands on {code,3'b111}, unless already inside the code window.
  - On arrival, go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=1.
  - Next state IDLE; cmd_ready returns to 1 the cycle after.
- busy=1 in SPIN, SEEK and DONE. cmd_ready = (state==IDLE) && !reset.
- Reset mid-operation: abort immediately, pos=0, no done pulse.
- Latency: (cmd_turns*256 + seek_steps) * STEP_DIV + 2 cycles from accept to done, for zero-bounce operation.

Optional Feature:
- Macro: DIAL_BOUNCE_EN.
- Defined:
  - On arrival, the block takes one extra step past the landing position in cmd_dir.
  - It then takes one step back, each step paced by the tick; then DONE.
  - Adds 2*STEP_DIV cycles; models mechanical overshoot for receiver robustness tests.
  - Implemented as an extra FSM state BOUNCE with a 1-bit phase.
- Undefined: no BOUNCE state; DONE follows arrival directly.

Decomposition:
- Package dial_pkg:
  - state enum (IDLE, SPIN, SEEK, DONE, BOUNCE).
  - POS_W and CODE_W constants.
  - typedefs pos_t (logic [7:0]) and code_t (logic [4:0]).
  - function bin2gray.
- Sub-module step_timer: tick counter with clear input and tick output, parameterised by STEP_DIV.
- The FSM and position register live in dial_encoder.

Test Plan:
- Basic CW seek: reset, STEP_DIV=4, cmd code=2, dir=CW, turns=0 -> 16 steps, pos=16, re_out=0x18. done at cycle 66 after accept; cmd_ready back the following cycle.
- CCW single step: from pos=16, cmd code=1, dir=CCW -> one step, pos=15, re_out=0x08, done 6 cycles after accept.
- CCW wrap: from pos=0, cmd code=31, dir=CCW -> pos=255, re_out=0x80 after one step.
- Full revolution: from pos=0, code=0, dir=CW, turns=1 -> 256 steps ending at pos=0, re_out=0. Checker sees 255 -> 0 wrap with a single-bit Gray change (0x80 -> 0x00). done after 1026 cycles.
- Already there, plus busy rejection:
  - From pos=16, cmd code=2, turns=0 -> zero steps, done 2 cycles after accept.
  - cmd_valid held while busy during a long command -> second command ignored until cmd_ready=1.
- Reset mid-spin: assert reset during SPIN at pos=100 -> next cycle pos=0, re_out=0, busy=0, no done pulse. With DIAL_BOUNCE_EN defined, the CW code=2 case shows 16 -> 17 -> 16 before done.
